// File: rtl/monolith_pkg.sv
// Shared types, default parameters and round-constant generator for the
// Monolith permutation controller.
package monolith_pkg;

  localparam int DEFAULT_WORD_WIDTH     = 31;
  localparam int DEFAULT_STATE_SIZE     = 16;
  localparam int DEFAULT_NUM_ROUNDS     = 6;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef logic [DEFAULT_STATE_SIZE-1:0][DEFAULT_WORD_WIDTH-1:0] perm_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } fsm_state_t;

  // Deterministic constant table: a multiplicative hash of (round, word),
  // folded once so the low bits depend on the high product bits too.
  function automatic logic [63:0] round_const_word(input int unsigned round_idx,
                                                   input int unsigned word_idx);
    logic [63:0] h;
    h = 64'(round_idx + 1) * 64'h0000_0000_9E37_79B1
      + 64'(word_idx)      * 64'h0000_0000_7F4A_7C15;
    h = h ^ (h >> 17);
    return h;
  endfunction

endpackage

// File: rtl/monolith_round_constants.sv
// Combinational round-constant ROM: NUM_ROUNDS-1 entries of STATE_SIZE words,
// indexed by round; out-of-range indices read as all-zero.
module monolith_round_constants
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int STATE_SIZE = DEFAULT_STATE_SIZE,
  parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
  parameter int IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic [IDX_W-1:0]                      round_idx,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] constants
);

  logic [63:0] rc_word;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    constants = '0;
    rc_word   = '0;
    if (int'(round_idx) < NUM_ROUNDS - 1) begin
      for (int w = 0; w < STATE_SIZE; w++) begin
        rc_word      = round_const_word(32'(round_idx), 32'(w));
        constants[w] = rc_word[WORD_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/monolith_perm_ctrl.sv
// Sequences one pre-round plus NUM_ROUNDS rounds through an external round
// datapath. Define MONOLITH_PERM_TIMEOUT_EN to add the WAIT timeout and err flag.
module monolith_perm_ctrl
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int STATE_SIZE = DEFAULT_STATE_SIZE,
  parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS
`ifdef MONOLITH_PERM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_state,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_state,
  output logic                                  rnd_reset,
  output logic                                  rnd_pre_round,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] rnd_state_in,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] rnd_constants,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] rnd_state_out,
  input  logic                                  rnd_valid,
  output logic                                  err
);

  localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

  fsm_state_t                            state_q, state_d;
  logic [CNT_W-1:0]                      round_q;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_reg_q;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] rom_constants;
  logic [CNT_W-1:0]                      rc_idx;
  logic                                  accept;
  logic                                  rnd_done;
  logic                                  last_round;
  logic                                  timeout_hit;

  assign accept     = in_valid && in_ready;
  assign rnd_done   = (state_q == WAIT) && rnd_valid;
  assign last_round = (round_q == CNT_W'(NUM_ROUNDS));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT: begin
        if (rnd_valid)        state_d = last_round ? DONE : LAUNCH;
        else if (timeout_hit) state_d = IDLE;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so the interface is quiet during the reset
  // cycle even before the state register has been forced back to IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rnd_reset = 1'b1;
    case (state_q)
      IDLE:    in_ready  = !reset;
      WAIT:    rnd_reset = reset;
      DONE:    out_valid = !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_q     <= '0;
      state_reg_q <= '0;
    end else if (accept) begin
      round_q     <= '0;
      state_reg_q <= in_state;
    end else if (rnd_done) begin
      state_reg_q <= rnd_state_out;
      if (!last_round) round_q <= round_q + 1'b1;
    end
  end

  // Pre-round (counter 0) and the final round (counter NUM_ROUNDS) take no
  // constants; rounds in between read ROM entry counter-1.
  assign rc_idx = round_q - 1'b1;

  monolith_round_constants #(
    .WORD_WIDTH (WORD_WIDTH),
    .STATE_SIZE (STATE_SIZE),
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (CNT_W)
  ) u_round_constants (
    .round_idx (rc_idx),
    .constants (rom_constants)
  );

  assign rnd_pre_round = (round_q == '0);
  assign rnd_state_in  = state_reg_q;
  assign rnd_constants = (round_q != '0 && !last_round) ? rom_constants : '0;
  assign out_state     = state_reg_q;

`ifdef MONOLITH_PERM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_q;
  logic            err_q;

  // Counts completed WAIT cycles; the TIMEOUT_CYCLES-th silent cycle aborts.
  assign timeout_hit = (state_q == WAIT) && !rnd_valid &&
                       (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT) wait_cnt_q <= '0;
    else if (!timeout_hit)        wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || accept) err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Scoreboard bench for monolith_perm_ctrl with a 4-cycle stub round datapath.
`timescale 1ns/1ps
module tb_monolith_perm_ctrl;
  import monolith_pkg::*;

  localparam int WW = 31;
  localparam int SS = 16;
  localparam int NR = 6;

  typedef logic [SS-1:0][WW-1:0] st_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  st_t  in_state = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  st_t  out_state;
  logic rnd_reset;
  logic rnd_pre_round;
  st_t  rnd_state_in;
  st_t  rnd_constants;
  st_t  rnd_state_out;
  logic rnd_valid = 1'b0;
  logic err;

  monolith_perm_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_state      (in_state),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state     (out_state),
    .rnd_reset     (rnd_reset),
    .rnd_pre_round (rnd_pre_round),
    .rnd_state_in  (rnd_state_in),
    .rnd_constants (rnd_constants),
    .rnd_state_out (rnd_state_out),
    .rnd_valid     (rnd_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  st_t exp_q[$];

  task automatic check(input string name, input logic [511:0] actual,
                       input logic [511:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference constant table and permutation, straight from the round rules.
  function automatic logic [WW-1:0] tb_rc(input int r, input int w);
    logic [63:0] h;
    h = 64'(r + 1) * 64'h9E3779B1 + 64'(w) * 64'h7F4A7C15;
    h = h ^ (h >> 17);
    return h[WW-1:0];
  endfunction

  function automatic st_t golden(input st_t s);
    st_t x = s;
    logic [WW-1:0] c;
    for (int w = 0; w < SS; w++) x[w] = x[w] + 1'b1;
    for (int r = 1; r <= NR; r++)
      for (int w = 0; w < SS; w++) begin
        c    = (r < NR) ? tb_rc(r - 1, w) : '0;
        x[w] = x[w] + c + 1'b1;
      end
    return x;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int w = 0; w < SS; w++) s[w] = WW'($urandom);
    return s;
  endfunction

  // Stub round: latch operands while rnd_reset is high, answer 4 cycles later.
  st_t  lat_in = '0;
  st_t  lat_c = '0;
  logic lat_pre = 1'b0;
  int   stub_cnt = 0;
  bit   stub_never = 1'b0;

  always @(posedge clk) begin
    if (rnd_reset) begin
      lat_in    <= rnd_state_in;
      lat_c     <= rnd_constants;
      lat_pre   <= rnd_pre_round;
      stub_cnt  <= 0;
      rnd_valid <= 1'b0;
    end else begin
      stub_cnt  <= stub_cnt + 1;
      rnd_valid <= !stub_never && (stub_cnt >= 3);
    end
  end

  always_comb begin
    rnd_state_out = '0;
    for (int w = 0; w < SS; w++)
      rnd_state_out[w] = lat_pre ? lat_in[w] + 1'b1 : lat_in[w] + lat_c[w] + 1'b1;
  end

  // Round invocation tracker: counts rnd_reset falling edges per request.
  int   inv_cnt = 0;
  bit   pre_bad = 1'b0;
  logic prev_rr = 1'b1;

  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      inv_cnt = 0;
      pre_bad = 1'b0;
    end else if (prev_rr && !rnd_reset) begin
      if ((inv_cnt == 0) != rnd_pre_round) pre_bad = 1'b1;
      inv_cnt++;
    end
    prev_rr = rnd_reset;
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    st_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("out_state", out_state, e);
          check("invocations", 512'(inv_cnt), 512'(NR + 1));
          check("pre_round_order", 512'(pre_bad), 512'(0));
        end
        @(negedge clk);
        check("in_ready_after_out", in_ready, 1'b1);
      end
    end
  end

  task automatic send(input st_t s);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("send_wait_in_ready");
    end else begin
      in_valid = 1'b1;
      in_state = s;
      @(posedge clk);
      exp_q.push_back(golden(s));
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 500) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) fail_now("wait_out_valid");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    @(negedge clk);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   ok;
    st_t  snap;
    st_t  ones;
    st_t  twos;
    int   n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rnd_reset", rnd_reset, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_pre_round", rnd_pre_round, 1'b1);
    check("post_rst_state_in", rnd_state_in, '0);
    check("post_rst_constants", rnd_constants, '0);

    // Zero input, out_ready held high: single-cycle out_valid.
    send('0);
    wait_out_valid(ok);
    if (ok) begin
      @(negedge clk);
      check("out_valid_one_cycle", out_valid, 1'b0);
    end
    wait_drain();

    // Back-pressure in DONE: result stable, in_valid ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    send(rand_st());
    wait_out_valid(ok);
    if (ok) begin
      snap = out_state;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        in_valid = i[0];
        in_state = rand_st();
        @(negedge clk);
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_out_state", out_state, snap);
        check("hold_in_ready", in_ready, 1'b0);
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset during the WAIT of round 3 abandons the request.
    send(rand_st());
    n = 0;
    while (!(inv_cnt == 4 && !rnd_reset) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) fail_now("reach_round3");
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_rnd_reset", rnd_reset, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_release_in_ready", in_ready, 1'b1);
    check("midrst_release_out_valid", out_valid, 1'b0);
    send(rand_st());
    wait_drain();

    // Back-to-back requests.
    for (int w = 0; w < SS; w++) begin
      ones[w] = WW'(1);
      twos[w] = WW'(2);
    end
    send(ones);
    send(twos);
    wait_drain();

    // Random data with random back-pressure.
    for (int k = 0; k < 4; k++) begin
      send(rand_st());
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
        @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      out_ready = 1'b1;
      if (exp_q.size() != 0) fail_now("random_drain");
    end
    wait_drain();

`ifdef MONOLITH_PERM_TIMEOUT_EN
    // Silent round datapath: err after 64 WAIT cycles, back to IDLE.
    stub_never = 1'b1;
    send(rand_st());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rnd_reset && n < 50);
    if (rnd_reset) fail_now("timeout_enter_wait");
    repeat (63) @(negedge clk);
    check("timeout_err_before", err, 1'b0);
    check("timeout_busy_before", in_ready, 1'b0);
    @(negedge clk);
    check("timeout_err", err, 1'b1);
    check("timeout_idle", in_ready, 1'b1);
    check("timeout_out_valid", out_valid, 1'b0);
    exp_q.delete();
    stub_never = 1'b0;
    send(rand_st());
    #1 check("timeout_err_cleared", err, 1'b0);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/monolith_perm_ctrl.md
MONOLITH_PERM_CTRL -- requirements
Module: monolith_perm_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 31, bits per state word.
REQ-002 SHALL have parameter STATE_SIZE, default 16, words per state.
REQ-003 SHALL have parameter NUM_ROUNDS, default 6, full rounds after the pre-round.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_state input STATE_SIZE x WORD_WIDTH: permutation request.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_state output STATE_SIZE x WORD_WIDTH: permutation result.
REQ-008 SHALL have ports rnd_reset output 1, rnd_pre_round output 1, rnd_state_in output STATE_SIZE x WORD_WIDTH, rnd_constants output STATE_SIZE x WORD_WIDTH: drive the round datapath.
REQ-009 SHALL have ports rnd_state_out input STATE_SIZE x WORD_WIDTH, rnd_valid input 1: round datapath result.
REQ-010 SHALL have port err output 1: round timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, LAUNCH, WAIT, DONE.
REQ-012 SHALL assert in_ready only in IDLE; in_valid&in_ready captures in_state into the state register, clears round counter to 0, enters LAUNCH.
REQ-013 SHALL hold rnd_reset high in every state except WAIT; the round datapath latches its operands during LAUNCH.
REQ-014 SHALL spend exactly one cycle in LAUNCH, then enter WAIT.
REQ-015 SHALL drive rnd_pre_round=1 when round counter is 0, else 0.
REQ-016 SHALL drive rnd_state_in from the state register at all times.
REQ-017 SHALL drive rnd_constants with ROM entry (counter-1) for counters 1..NUM_ROUNDS-1, and all-zero for counters 0 and NUM_ROUNDS.
REQ-018 SHALL, in WAIT, ignore rnd_valid until it is first sampled high; on that cycle it SHALL load rnd_state_out into the state register.
REQ-019 SHALL, on that cycle, go to DONE if counter==NUM_ROUNDS, else increment the counter and go to LAUNCH.
REQ-020 SHALL hold out_valid high in DONE with out_state equal to the state register, stable until out_ready.
REQ-021 SHALL return to IDLE on out_valid&out_ready; in_ready SHALL be 1 the following cycle.
REQ-022 SHALL ignore in_valid outside IDLE; no request queuing.
REQ-023 SHALL sequence exactly NUM_ROUNDS+1 round invocations per request: one pre-round, then NUM_ROUNDS rounds.
REQ-024 SHALL size the round counter as $clog2(NUM_ROUNDS+1) bits; it SHALL never exceed NUM_ROUNDS.

Reset
REQ-025 SHALL, while reset is high, set state IDLE, counter 0, state register 0, out_valid 0, err 0, rnd_reset 1.
REQ-026 SHALL abandon any in-flight permutation on reset; no result is emitted for it.
REQ-027 SHALL drive in_ready=0 while reset is high, and 1 on the first cycle after reset is released.

Configuration
REQ-028 SHALL define macro MONOLITH_PERM_TIMEOUT_EN, parameter TIMEOUT_CYCLES default 64.
REQ-029 With the macro: a WAIT cycle counter SHALL be cleared on entering WAIT; when it reaches TIMEOUT_CYCLES without rnd_valid, err SHALL be set (sticky until reset or the next accepted request) and the FSM SHALL go to IDLE with out_valid 0.
REQ-030 Without the macro: no timeout counter; err SHALL be tied 0; WAIT SHALL last indefinitely.

Structure
REQ-031 SHALL place the state type (STATE_SIZE x WORD_WIDTH word array), the FSM state enum and the default parameters in shared package monolith_pkg.
REQ-032 SHALL instantiate sub-module monolith_round_constants: combinational ROM indexed by round, NUM_ROUNDS-1 entries of STATE_SIZE words.

Verification
REQ-033 Bench SHALL use a stub round with a fixed 4-cycle rnd_valid latency after rnd_reset falls and out = in + constants + 1 per word (pre-round: in + 1).
REQ-034 Zero input, out_ready=1 -> exactly 7 rnd_reset falling edges; first with rnd_pre_round=1; out_state matches the golden model; out_valid high for one cycle.
REQ-035 out_ready held 0 for 10 cycles in DONE -> out_valid and out_state stable; in_ready stays 0; in_valid pulses are ignored.
REQ-036 Reset asserted in WAIT of round 3 -> next cycle state IDLE, out_valid 0; a fresh request then completes with a correct result.
REQ-037 Back-to-back requests 0x1 and 0x2 per word -> two results in order, each correct; in_ready 1 the cycle after each handshake.
REQ-038 With MONOLITH_PERM_TIMEOUT_EN, stub never raises rnd_valid -> err=1 after 64 WAIT cycles, FSM in IDLE; next accepted request clears err.
